sensor_pkt_sink: RTL
====================

// Module: sensor_pkt_sink
// PURPOSE
//  Downstream consumer of the 3-flit sensor packets (temperature / VCCINT) injected by the XADC network interface.
//  Parses the head/body/tail flit stream, checks framing and tail consistency, and commits 24-bit readings
//  into a per-node sensor table.
//  Sits at the monitoring node's ejection port and feeds the host-readable status logic.
// PARAMETERS
//  NODES    16  table depth, indexed by source ID; must be <= 16 because the flit ID field is 4 bits
//  ERR_W    16  width of the saturating framing-error counter
// PORTS
//  clk        in   1      single clock; every register samples on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  Valid_i    in   1      flit valid from the network
//  Data_i     in   32     flit payload
//  Ready_o    out  1      flit accept; Ready_o = ~rst & ~Hold_i
//  Hold_i     in   1      backpressure request from the consumer side
//  RdAddr_i   in   4      table read index
//  RdTemp_o   out  24     stored temperature for RdAddr_i (combinational read)
//  RdVcc_o    out  24     stored VCCINT for RdAddr_i (combinational read)
//  RdVld_o    out  2      {vcc_valid, temp_valid} for RdAddr_i
//  Update_o   out  1      one-cycle pulse after each commit
//  UpdID_o    out  4      source ID of the last commit
//  UpdType_o  out  1      type of the last commit: 0 = temperature (code 26), 1 = VCCINT (code 27)
//  ErrCnt_o   out  ERR_W  framing/consistency errors, saturating
//  ClrErr_i   in   1      synchronous clear of ErrCnt_o
// BEHAVIOUR
//  Flit formats (f = Data_i):
//   - head: f[31:30]=00, f[29]=1, ID=f[8:5], code=f[4:0]
//   - body: f[31:30]=01, data=f[23:0]
//   - tail: f[31:30]=11, chk=f[7:0]
//  Transfer: a flit is accepted only on a cycle with Valid_i & Ready_o; unaccepted flits are ignored.
//  FSM (IDLE/BODY/TAIL/DROP). Every transition below happens on an accepted flit.
//   - IDLE: head with code 26/27 -> latch ID and type, go to BODY.
//           Head with any other code -> error, go to DROP. Any non-head -> error, stay in IDLE.
//   - BODY: body -> latch data[23:0], go to TAIL.
//           Head -> error, then process the flit as a new head, as in IDLE. Tail -> error, go to IDLE.
//   - TAIL: tail with chk == data[7:0] -> commit, go to IDLE.
//           Tail with mismatch -> error, no commit, go to IDLE.
//           Head -> error, process it as a new head. Body -> error, go to DROP.
//   - DROP: discard flits until a tail is accepted, then go to IDLE. Flits discarded here raise no further errors.
//   - Flits with f[31:30]=10 are always an error; the FSM then behaves as for an unexpected body.
//  Commit:
//   - Writes table[ID] (temp or vcc array) and sets its valid bit on the edge that accepts the tail.
//   - Update_o, UpdID_o and UpdType_o are registered and appear the following cycle (latency 1).
//   - A head whose ID >= NODES still runs through the FSM, but a good tail neither writes the table nor pulses Update_o.
//  Reads are combinational from registers. A same-cycle read of the entry being written returns the old value;
//  the new value is visible the next cycle.
//  Error counter:
//   - +1 per error event, saturates at all ones.
//   - ClrErr_i has priority over a same-cycle error, so the result is 0.
//  Hold_i mid-packet stalls the FSM in place; no state or data is lost.
//  Reset, asserted at any time including mid-packet:
//   - FSM -> IDLE; table data and valid bits -> 0; Update_o = 0; UpdID_o/UpdType_o = 0; ErrCnt_o = 0.
//   - Ready_o = 0 while rst is high.
//   - A partial packet arriving after reset is handled by the normal IDLE error rules.
// STRUCTURE
//  Shared package sensor_noc_pkg:
//   - flit type constants FLIT_HEAD=2'b00, FLIT_BODY=2'b01, FLIT_TAIL=2'b11
//   - sensor codes SENS_TEMP=5'd26, SENS_VCC=5'd27
//   - the sink FSM state encoding
//  One sub-module, sensor_table: two NODES x 24 register arrays plus valid bits, one write port, one combinational read port.
//  FSM, checks and error counter stay in the top level.
// TESTING
//  1. Send ID=3 VCC packet: 0x2000007B, 0x40ABCDEF, 0xC00000EF.
//     -> RdVcc_o(3)=0xABCDEF, RdVld_o(3)=2'b10, one Update_o pulse with UpdID_o=3, UpdType_o=1, ErrCnt_o=0.
//  2. Send temp packet ID=5 with tail chk 0x00 and body 0x400123FF.
//     -> no commit, RdVld_o(5)=0, ErrCnt_o=1.
//  3. Send head ID=2 temp, then head ID=4 temp 0x2000009A, body 0x40000111, tail 0xC0000011.
//     -> ErrCnt_o=1, RdTemp_o(4)=0x000111, ID 2 not written.
//  4. Send head with code 5'd9, body, tail, then a valid ID=1 temp packet.
//     -> ErrCnt_o=1 (DROP is silent), ID 1 committed.
//  5. Hold_i=1 for 4 cycles between body and tail, Valid_i held high.
//     -> Ready_o=0 for those 4 cycles, a single commit afterwards with correct data.
//  6. Assert rst after the body of a packet, then send its tail.
//     -> outputs reset, the tail counts as 1 error, table stays empty.
//     Force ErrCnt to all ones, then inject one more error -> ErrCnt_o stays all ones.
//     Assert ClrErr_i together with an error -> ErrCnt_o = 0.

Source files
------------

// File: rtl/sensor_noc_pkg.sv
// Shared definitions for the sensor NoC sink: flit type codes, sensor codes,
// sink FSM state encoding and small flit-decoding helpers.
package sensor_noc_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b00;
  localparam logic [1:0] FLIT_BODY = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  localparam logic [4:0] SENS_TEMP = 5'd26;
  localparam logic [4:0] SENS_VCC  = 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2,
    ST_DROP = 2'd3
  } sink_state_e;

  // Decoded flit class; FK_BAD covers type 2'b10 and a type-00 flit without the head marker bit
  typedef enum logic [1:0] {
    FK_HEAD = 2'd0,
    FK_BODY = 2'd1,
    FK_TAIL = 2'd2,
    FK_BAD  = 2'd3
  } flit_kind_e;

  function automatic flit_kind_e flit_kind(input logic [31:0] f);
    flit_kind_e k;
    k = FK_BAD;
    if (f[31:30] == FLIT_HEAD && f[29]) k = FK_HEAD;
    else if (f[31:30] == FLIT_BODY)     k = FK_BODY;
    else if (f[31:30] == FLIT_TAIL)     k = FK_TAIL;
    return k;
  endfunction

  function automatic logic is_sens_code(input logic [4:0] code);
    return (code == SENS_TEMP) || (code == SENS_VCC);
  endfunction

endpackage

// File: rtl/sensor_table.sv
// Per-node sensor table: temperature and VCCINT readings with valid bits.
// One write port (commit from the sink FSM), one combinational read port.
// A read of the entry being written in the same cycle returns the old value.
module sensor_table #(
  parameter int NODES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_addr,
  input  logic        i_wr_vcc,
  input  logic [23:0] i_wr_data,
  input  logic [3:0]  i_rd_addr,
  output logic [23:0] o_rd_temp,
  output logic [23:0] o_rd_vcc,
  output logic [1:0]  o_rd_vld
);

  logic [23:0] r_temp [NODES];
  logic [23:0] r_vcc  [NODES];
  logic        r_tvld [NODES];
  logic        r_vvld [NODES];

  logic w_wr_ok;
  logic w_rd_ok;

  assign w_wr_ok = i_wr_en && (32'(i_wr_addr) < NODES);
  assign w_rd_ok = (32'(i_rd_addr) < NODES);

  // Table storage: cleared on reset, one entry written per commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) begin
        r_temp[i] <= '0;
        r_vcc[i]  <= '0;
        r_tvld[i] <= 1'b0;
        r_vvld[i] <= 1'b0;
      end
    end else if (w_wr_ok) begin
      if (i_wr_vcc) begin
        r_vcc[i_wr_addr]  <= i_wr_data;
        r_vvld[i_wr_addr] <= 1'b1;
      end else begin
        r_temp[i_wr_addr] <= i_wr_data;
        r_tvld[i_wr_addr] <= 1'b1;
      end
    end
  end

  // Combinational read port; out-of-range indices read as empty
  always_comb begin
    o_rd_temp = '0;
    o_rd_vcc  = '0;
    o_rd_vld  = 2'b00;
    if (w_rd_ok) begin
      o_rd_temp = r_temp[i_rd_addr];
      o_rd_vcc  = r_vcc[i_rd_addr];
      o_rd_vld  = {r_vvld[i_rd_addr], r_tvld[i_rd_addr]};
    end
  end

endmodule

// File: rtl/sensor_pkt_sink.sv
// Sensor packet sink: parses 3-flit head/body/tail packets from the NoC
// ejection port, checks framing and the tail check byte, and commits the
// 24-bit reading into the per-node sensor table.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for a head flit
//   ST_BODY | head with a sensor code accepted, waiting for the body
//   ST_TAIL | body latched, waiting for the tail check byte
//   ST_DROP | bad head seen, silently discarding flits up to a tail
//
// NODES must not exceed 16: the head flit carries a 4-bit source ID.
module sensor_pkt_sink
  import sensor_noc_pkg::*;
#(
  parameter int NODES = 16,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_i,
  input  logic [31:0]      Data_i,
  output logic             Ready_o,
  input  logic             Hold_i,
  input  logic [3:0]       RdAddr_i,
  output logic [23:0]      RdTemp_o,
  output logic [23:0]      RdVcc_o,
  output logic [1:0]       RdVld_o,
  output logic             Update_o,
  output logic [3:0]       UpdID_o,
  output logic             UpdType_o,
  output logic [ERR_W-1:0] ErrCnt_o,
  input  logic             ClrErr_i
);

  sink_state_e r_state;
  sink_state_e w_state_nxt;

  logic [3:0]       r_id;
  logic             r_vcc;
  logic [23:0]      r_data;
  logic             r_update;
  logic [3:0]       r_upd_id;
  logic             r_upd_type;
  logic [ERR_W-1:0] r_err_cnt;

  logic       w_accept;
  flit_kind_e w_kind;
  logic       w_head_ok;
  logic       w_err;
  logic       w_commit;
  logic       w_ld_head;
  logic       w_ld_body;
  logic       w_id_ok;

  assign Ready_o   = ~rst & ~Hold_i;
  assign w_accept  = Valid_i & Ready_o;
  assign w_kind    = flit_kind(Data_i);
  assign w_head_ok = is_sens_code(Data_i[4:0]);
  assign w_id_ok   = (32'(r_id) < NODES);

  // Next-state and per-flit decisions; at most one error event per accepted flit
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_commit    = 1'b0;
    w_ld_head   = 1'b0;
    w_ld_body   = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_kind == FK_HEAD) begin
            if (w_head_ok) begin
              w_ld_head   = 1'b1;
              w_state_nxt = ST_BODY;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_DROP;
            end
          end else begin
            w_err = 1'b1;
          end
        end
        ST_BODY: begin
          case (w_kind)
            FK_BODY: begin
              w_ld_body   = 1'b1;
              w_state_nxt = ST_TAIL;
            end
            FK_HEAD: begin
              // Lost tail: restart on the new head
              w_err = 1'b1;
              if (w_head_ok) begin
                w_ld_head   = 1'b1;
                w_state_nxt = ST_BODY;
              end else begin
                w_state_nxt = ST_DROP;
              end
            end
            FK_TAIL: begin
              w_err       = 1'b1;
              w_state_nxt = ST_IDLE;
            end
            default: begin
              w_err       = 1'b1;
              w_state_nxt = ST_DROP;
            end
          endcase
        end
        ST_TAIL: begin
          case (w_kind)
            FK_TAIL: begin
              if (Data_i[7:0] == r_data[7:0]) w_commit = 1'b1;
              else                            w_err    = 1'b1;
              w_state_nxt = ST_IDLE;
            end
            FK_HEAD: begin
              w_err = 1'b1;
              if (w_head_ok) begin
                w_ld_head   = 1'b1;
                w_state_nxt = ST_BODY;
              end else begin
                w_state_nxt = ST_DROP;
              end
            end
            default: begin
              w_err       = 1'b1;
              w_state_nxt = ST_DROP;
            end
          endcase
        end
        ST_DROP: begin
          if (w_kind == FK_TAIL) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Packet context: source ID and type from the head, reading from the body
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id   <= '0;
      r_vcc  <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_ld_head) begin
        r_id  <= Data_i[8:5];
        r_vcc <= (Data_i[4:0] == SENS_VCC);
      end
      if (w_ld_body) r_data <= Data_i[23:0];
    end
  end

  // Commit notification, one cycle after the tail is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_update   <= 1'b0;
      r_upd_id   <= '0;
      r_upd_type <= 1'b0;
    end else begin
      r_update <= w_commit & w_id_ok;
      if (w_commit && w_id_ok) begin
        r_upd_id   <= r_id;
        r_upd_type <= r_vcc;
      end
    end
  end

  // Saturating error counter; clear wins over a same-cycle error
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_err_cnt <= '0;
    else if (ClrErr_i)                           r_err_cnt <= '0;
    else if (w_err && (r_err_cnt != {ERR_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
  end

  sensor_table #(
    .NODES (NODES)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_commit),
    .i_wr_addr (r_id),
    .i_wr_vcc  (r_vcc),
    .i_wr_data (r_data),
    .i_rd_addr (RdAddr_i),
    .o_rd_temp (RdTemp_o),
    .o_rd_vcc  (RdVcc_o),
    .o_rd_vld  (RdVld_o)
  );

  assign Update_o  = r_update;
  assign UpdID_o   = r_upd_id;
  assign UpdType_o = r_upd_type;
  assign ErrCnt_o  = r_err_cnt;

endmodule
